// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock through a half-adder ripple
// chain and presents the registered result under a valid/ready handshake.
module serial_adder #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             overflow
);

   localparam int unsigned N     = (DIGIT == 0) ? 1 : WIDTH / DIGIT;
   localparam int unsigned CNT_W = (N + 1 > 2) ? $clog2(N + 1) : 1;
   localparam int unsigned DW    = (DIGIT == 0) ? 1 : DIGIT;

   generate
      if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DW) != 0) begin : g_bad_param
         $error("serial_adder: WIDTH must be >= 2 and an exact multiple of DIGIT >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   res_q;
   logic               carry_q;

   logic [DW-1:0]      dig_a;
   logic [DW-1:0]      dig_b;
   logic [DW-1:0]      dig_sum;
   logic               dig_cout;
   logic               dig_cmsb;
   logic [WIDTH-1:0]   res_next;

   // Select the current digit, ripple it through two half adders per bit, merge into result
   always_comb begin : digit_add
      logic [DW:0] ch;
      logic        hs;
      logic        hc1;
      logic        hc2;
      dig_a    = '0;
      dig_b    = '0;
      dig_sum  = '0;
      ch       = '0;
      hs       = 1'b0;
      hc1      = 1'b0;
      hc2      = 1'b0;
      res_next = res_q;
      for (int k = 0; k < int'(N); k++) begin
         if (cnt == CNT_W'(k)) begin
            dig_a = a_q[k*DW +: DW];
            dig_b = b_q[k*DW +: DW];
         end
      end
      ch[0] = carry_q;
      for (int i = 0; i < int'(DW); i++) begin
         hs         = dig_a[i] ^ dig_b[i];
         hc1        = dig_a[i] & dig_b[i];
         dig_sum[i] = hs ^ ch[i];
         hc2        = hs & ch[i];
         ch[i+1]    = hc1 | hc2;
      end
      dig_cout = ch[DW];
      dig_cmsb = ch[DW-1];
      for (int k = 0; k < int'(N); k++) begin
         if (cnt == CNT_W'(k)) begin
            res_next[k*DW +: DW] = dig_sum;
         end
      end
   end

   // Control FSM with registered handshake flags and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         carry_q   <= 1'b0;
         sum       <= '0;
         carry     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  b_q      <= sub ? ~b : b;
                  carry_q  <= sub ? 1'b1 : cin;
                  res_q    <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               res_q   <= res_next;
               carry_q <= dig_cout;
               if (cnt == CNT_W'(N - 1)) begin
                  // Last digit: its carry into the top bit decides signed overflow
                  sum       <= res_next;
                  carry     <= dig_cout;
                  overflow  <= dig_cout ^ dig_cmsb;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: one 1-bit-digit and one 4-bit-digit instance
// checked against an integer-arithmetic reference model.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       sub;

   logic       iv1, or1, ir1, ov1, c1, f1;
   logic [7:0] s1;
   logic       iv4, or4, ir4, ov4, c4, f4;
   logic [7:0] s4;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov1), .out_ready(or1), .sum(s1), .carry(c1), .overflow(f1)
   );

   serial_adder #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(ov4), .out_ready(or4), .sum(s4), .carry(c4), .overflow(f4)
   );

   // Reference: plain integer arithmetic, unsigned for sum/carry, signed for overflow
   task automatic model(input logic [7:0] x, input logic [7:0] y, input logic ci,
                        input logic sb, output logic [7:0] s, output logic c, output logic o);
      int ux, uy, sx, sy, r, sr;
      ux = int'(x);
      uy = int'(y);
      sx = (ux >= 128) ? ux - 256 : ux;
      sy = (uy >= 128) ? uy - 256 : uy;
      if (sb) begin
         r  = ux - uy;
         c  = (ux >= uy);
         sr = sx - sy;
      end else begin
         r  = ux + uy + int'(ci);
         c  = (r > 255);
         sr = sx + sy + int'(ci);
      end
      s = 8'(r);
      o = (sr > 127) || (sr < -128);
   endtask

   task automatic do_op(input bit sel, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic sb, output int lat,
                        output logic [7:0] s, output logic c, output logic o);
      a = x; b = y; cin = ci; sub = sb;
      if (sel) iv4 = 1'b1; else iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0; iv4 = 1'b0;
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!(sel ? ov4 : ov1) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      s = sel ? s4 : s1;
      c = sel ? c4 : c1;
      o = sel ? f4 : f1;
      if (sel) or4 = 1'b1; else or1 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0; or4 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; iv1 = 1'b0; iv4 = 1'b0; or1 = 1'b0; or4 = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({ir1, ov1, s1, c1, f1} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
         $display("FAIL reset_d1 got ir=%b ov=%b sum=%h c=%b o=%b want 1 0 00 0 0", ir1, ov1, s1, c1, f1);
      else n_pass++;
      n_checks++;
      if ({ir4, ov4, s4, c4, f4} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
         $display("FAIL reset_d4 got ir=%b ov=%b sum=%h c=%b o=%b want 1 0 00 0 0", ir4, ov4, s4, c4, f4);
      else n_pass++;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_vectors();
      bit         vsel[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [7:0] va[6]   = '{8'hFF, 8'h7F, 8'h05, 8'h07, 8'h3C, 8'h80};
      logic [7:0] vb[6]   = '{8'h01, 8'h01, 8'h07, 8'h05, 8'h4B, 8'h01};
      logic       vci[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic       vsb[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] es[6]   = '{8'h00, 8'h80, 8'hFE, 8'h02, 8'h88, 8'h7F};
      logic       ec[6]   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       eo[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      int         lat;
      logic [7:0] s;
      logic       c, o;
      for (int i = 0; i < 6; i++) begin
         do_op(vsel[i], va[i], vb[i], vci[i], vsb[i], lat, s, c, o);
         n_checks++;
         if (lat !== (vsel[i] ? 2 : 8))
            $display("FAIL vec%0d_latency got %0d want %0d", i, lat, vsel[i] ? 2 : 8);
         else n_pass++;
         n_checks++;
         if ({s, c, o} !== {es[i], ec[i], eo[i]})
            $display("FAIL vec%0d_result got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     i, s, c, o, es[i], ec[i], eo[i]);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int         lat;
      logic [7:0] x, y, s, ms;
      logic       ci, sb, c, o, mc, mo;
      bit         sel;
      for (int i = 0; i < 60; i++) begin
         sel = 1'(i % 2);
         x = 8'($urandom); y = 8'($urandom); ci = 1'($urandom); sb = 1'($urandom);
         model(x, y, ci, sb, ms, mc, mo);
         do_op(sel, x, y, ci, sb, lat, s, c, o);
         n_checks++;
         if (lat !== (sel ? 2 : 8))
            $display("FAIL rand%0d_latency got %0d want %0d", i, lat, sel ? 2 : 8);
         else n_pass++;
         n_checks++;
         if ({s, c, o} !== {ms, mc, mo})
            $display("FAIL rand%0d a=%h b=%h cin=%b sub=%b got sum=%h c=%b o=%b want sum=%h c=%b o=%b",
                     i, x, y, ci, sb, s, c, o, ms, mc, mo);
         else n_pass++;
      end
   endtask

   task automatic test_hold();
      int cyc;
      a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; iv1 = 1'b1;
      @(posedge clk); #1;
      a = 8'hAA; b = 8'h55; cin = 1'b1;
      cyc = 0;
      while (!ov1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if ({ov1, s1, ir1} !== {1'b1, 8'h46, 1'b0})
            $display("FAIL hold%0d got ov=%b sum=%h ir=%b want 1 46 0", i, ov1, s1, ir1);
         else n_pass++;
         @(posedge clk); #1;
      end
      iv1 = 1'b0; or1 = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({ir1, ov1, s1} !== {1'b1, 1'b0, 8'h46})
         $display("FAIL hold_release got ir=%b ov=%b sum=%h want 1 0 46", ir1, ov1, s1);
      else n_pass++;
      // out_ready stays high in IDLE and early RUN; it must not matter there
      a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({ov1, s1, ir1} !== {1'b0, 8'h46, 1'b0})
         $display("FAIL run_keeps_sum got ov=%b sum=%h ir=%b want 0 46 0", ov1, s1, ir1);
      else n_pass++;
      or1 = 1'b0;
      cyc = 3;
      while (!ov1 && cyc < 40) begin @(posedge clk); #1; cyc++; end
      n_checks++;
      if ({cyc, s1} !== {32'd8, 8'h02})
         $display("FAIL after_hold got lat=%0d sum=%h want 8 02", cyc, s1);
      else n_pass++;
      or1 = 1'b1;
      @(posedge clk); #1;
      or1 = 1'b0;
   endtask

   task automatic test_reset_mid();
      int         lat;
      logic [7:0] s;
      logic       c, o;
      a = 8'h55; b = 8'h22; cin = 1'b0; sub = 1'b0; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({ir1, ov1, s1, c1, f1} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0})
         $display("FAIL reset_mid got ir=%b ov=%b sum=%h c=%b o=%b want 1 0 00 0 0", ir1, ov1, s1, c1, f1);
      else n_pass++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_op(1'b0, 8'h10, 8'h20, 1'b0, 1'b0, lat, s, c, o);
      n_checks++;
      if ({lat, s, c, o} !== {32'd8, 8'h30, 1'b0, 1'b0})
         $display("FAIL post_reset_op got lat=%0d sum=%h c=%b o=%b want 8 30 0 0", lat, s, c, o);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_hold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, operand and result width in bits; legal values are 2 or more.
REQ-002 The module SHALL have parameter DIGIT, default 1, bits processed per clock; WIDTH SHALL be an exact multiple of DIGIT.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand set is presented.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 cin  input  1  carry-in; ignored when sub=1.
REQ-010 sub  input  1  0 = a+b+cin; 1 = a-b, computed as a+~b+1.
REQ-011 out_valid  output  1  result is presented.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 carry  output  1  carry out of the MSB; for sub=1, 1 means no borrow (a>=b unsigned).
REQ-015 overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

Function
REQ-016 Let N = WIDTH/DIGIT; the FSM SHALL have exactly three states: IDLE, RUN and HOLD.
REQ-017 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in HOLD; both are registered-state decodes.
REQ-018 In IDLE, in_valid=1 at a rising edge SHALL capture a, b, cin and sub, clear the digit counter, and move to RUN.
REQ-019 In RUN, each cycle SHALL add digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1) of both captured operands plus the stored carry, using a ripple chain of half-adder cells, and store the result digit and the carry-out.
REQ-020 The initial stored carry SHALL be cin when sub=0, and 1 when sub=1 (with b inverted).
REQ-021 After the N-th RUN cycle, the next edge SHALL load sum, carry and overflow and move to HOLD.
REQ-022 out_valid SHALL therefore rise exactly N cycles after the accepting edge.
REQ-023 In HOLD, sum, carry and overflow SHALL stay constant until out_valid&out_ready is sampled at an edge, which SHALL move the FSM to IDLE.
REQ-024 sum, carry and overflow SHALL keep the last result outside HOLD and SHALL change only on entry to HOLD.
REQ-025 in_valid asserted outside IDLE SHALL be ignored, with no capture; there is no overlap of operations.
REQ-026 in_valid and out_ready SHALL be ignored in the states where they carry no meaning.
REQ-027 The counter SHALL be wide enough for N and SHALL NOT wrap during RUN.
REQ-028 Illegal WIDTH or DIGIT values SHALL cause an elaboration-time error.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, with in_ready=1, out_valid=0, sum=0, carry=0, overflow=0, and the counter and operand registers cleared.
REQ-030 Reset during RUN or HOLD SHALL discard the operation; the first operation after release SHALL behave as one after power-up.

Verification
REQ-031 WIDTH=8, DIGIT=1, a=FF, b=01, cin=0, sub=0 -> sum=00, carry=1, overflow=0; out_valid rises 8 cycles after accept.
REQ-032 WIDTH=8, DIGIT=1, a=7F, b=01, cin=0 -> sum=80, carry=0, overflow=1.
REQ-033 sub=1: a=05, b=07 -> sum=FE, carry=0, overflow=0; a=07, b=05 -> sum=02, carry=1, overflow=0.
REQ-034 out_ready held 0 for 5 cycles in HOLD, with in_valid held 1 -> out_valid and sum stable, in_ready=0, no new capture; out_ready=1 -> IDLE next edge.
REQ-035 rst_n pulsed low at RUN cycle 3 -> out_valid=0 and sum=00 at once, in_ready=1; the next op a=10, b=20 gives sum=30.
REQ-036 WIDTH=8, DIGIT=4, a=3C, b=4B, cin=1 -> sum=88, carry=0, overflow=1; out_valid rises 2 cycles after accept.
